// File: rtl/token_scheduler.sv
// Round-robin token scheduler: per-requester saturating pending counters feed one
// valid/ready output slot, served cyclically starting after the last issued requester.
module token_scheduler #(
  parameter int N = 4,
  parameter int CNT_W = 4,
  localparam int ID_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    a,
  input  logic [N-1:0]    double_en,
  input  logic            b_ready,
  output logic            b,
  output logic [ID_W-1:0] b_id,
  output logic [N-1:0]    overflow,
  output logic            busy
);

  localparam logic [CNT_W+1:0] MAX = (CNT_W+2)'((1 << CNT_W) - 1);

  logic [CNT_W-1:0] pending_reg  [N];
  logic [CNT_W-1:0] pending_next [N];
  logic [N-1:0]     overflow_reg;
  logic [N-1:0]     ovf_hit;
  logic [N-1:0]     nonzero;
  logic             b_reg;
  logic [ID_W-1:0]  b_id_reg;
  logic [ID_W-1:0]  ptr_reg;
  logic [ID_W-1:0]  winner;
  logic             found;
  logic             load;

  // The slot can take a new token when empty or when its token leaves this cycle.
  assign load = !b_reg || b_ready;

  always_comb begin
    logic [ID_W-1:0] idx;
    found  = 1'b0;
    winner = ptr_reg;
    idx    = ptr_reg;
    for (int k = 1; k <= N; k++) begin
      idx = ID_W'((int'(ptr_reg) + k) % N);
      if (!found && nonzero[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_req
    logic [CNT_W+1:0] weight;
    logic [CNT_W+1:0] take;
    logic [CNT_W+1:0] sum;

    assign weight = a[gi] ? (double_en[gi] ? (CNT_W+2)'(2) : (CNT_W+2)'(1)) : '0;
    assign take   = (load && found && (winner == ID_W'(gi))) ? (CNT_W+2)'(1) : '0;
    // Two guard bits keep the sum exact so saturation can be detected.
    assign sum    = {2'b00, pending_reg[gi]} + weight - take;
    assign ovf_hit[gi]      = sum > MAX;
    assign pending_next[gi] = ovf_hit[gi] ? MAX[CNT_W-1:0] : sum[CNT_W-1:0];
    assign nonzero[gi]      = |pending_reg[gi];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) pending_reg[i] <= '0;
      b_reg        <= 1'b0;
      b_id_reg     <= '0;
      ptr_reg      <= ID_W'(N - 1);
      overflow_reg <= '0;
    end else begin
      for (int i = 0; i < N; i++) pending_reg[i] <= pending_next[i];
      overflow_reg <= overflow_reg | ovf_hit;
      if (load) begin
        if (found) begin
          b_reg    <= 1'b1;
          b_id_reg <= winner;
          ptr_reg  <= winner;
        end else begin
          b_reg <= 1'b0;
        end
      end
    end
  end

  assign b        = b_reg;
  assign b_id     = b_id_reg;
  assign overflow = overflow_reg;
  assign busy     = b_reg || (|nonzero);

endmodule

// File: tb/tb_token_scheduler.sv
// Bench for token_scheduler: two instances (CNT_W=4 and CNT_W=8) checked every cycle
// against a counting model, plus directed literal expectations and a conservation scoreboard.
module tb_token_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] de;
  logic       b_ready;
  logic       dut_b    [2];
  logic [1:0] dut_id   [2];
  logic [3:0] dut_ovf  [2];
  logic       dut_busy [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  token_scheduler #(.N(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .a(a), .double_en(de), .b_ready(b_ready),
    .b(dut_b[0]), .b_id(dut_id[0]), .overflow(dut_ovf[0]), .busy(dut_busy[0])
  );

  token_scheduler #(.N(4), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .a(a), .double_en(de), .b_ready(b_ready),
    .b(dut_b[1]), .b_id(dut_id[1]), .overflow(dut_ovf[1]), .busy(dut_busy[1])
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Model: counts of owed tokens per requester, the slot, and the last served id.
  int m_pend [2][4];
  int m_b    [2];
  int m_id   [2];
  int m_last [2];
  int m_ovf  [2][4];
  bit cmp_en = 1'b0;

  always @(posedge clk) begin
    for (int j = 0; j < 2; j++) begin
      int mx;
      bit ld;
      bit fnd;
      int win;
      int c;
      int nx;
      mx = (j == 0) ? 15 : 255;
      if (!rst_n) begin
        for (int i = 0; i < 4; i++) begin
          m_pend[j][i] = 0;
          m_ovf[j][i]  = 0;
        end
        m_b[j] = 0; m_id[j] = 0; m_last[j] = 3;
      end else begin
        ld  = (m_b[j] == 0) || b_ready;
        fnd = 1'b0;
        win = 0;
        for (int k = 1; k <= 4; k++) begin
          c = (m_last[j] + k) % 4;
          if (!fnd && m_pend[j][c] > 0) begin
            fnd = 1'b1;
            win = c;
          end
        end
        for (int i = 0; i < 4; i++) begin
          nx = m_pend[j][i] + (a[i] ? (de[i] ? 2 : 1) : 0) - ((ld && fnd && win == i) ? 1 : 0);
          if (nx > mx) begin
            m_pend[j][i] = mx;
            m_ovf[j][i]  = 1;
          end else begin
            m_pend[j][i] = nx;
          end
        end
        if (ld) begin
          if (fnd) begin
            m_b[j] = 1; m_id[j] = win; m_last[j] = win;
          end else begin
            m_b[j] = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int j = 0; j < 2; j++) begin
        int eb;
        int eovf;
        eb = m_b[j];
        eovf = 0;
        for (int i = 0; i < 4; i++) begin
          if (m_pend[j][i] > 0) eb = 1;
          eovf = eovf | (m_ovf[j][i] << i);
        end
        chk($sformatf("model_b[%0d]", j), int'(dut_b[j]), m_b[j]);
        if (m_b[j] != 0) chk($sformatf("model_id[%0d]", j), int'(dut_id[j]), m_id[j]);
        chk($sformatf("model_ovf[%0d]", j), int'(dut_ovf[j]), eovf);
        chk($sformatf("model_busy[%0d]", j), int'(dut_busy[j]), eb);
      end
    end
  end

  // Conservation scoreboard on the CNT_W=8 instance.
  bit cons_en = 1'b0;
  int acc [4];
  int posted [4];

  always @(negedge clk) begin
    if (cons_en && rst_n && dut_b[1] && b_ready) begin
      acc[dut_id[1]]++;
    end
    if (!cons_en && rst_n && dut_b[0] && b_ready) begin
      $display("xfer t=%0t id=%0d", $time, dut_id[0]);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; a = '0; de = '0; b_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_b", int'(dut_b[0]), 0);
    chk("rst_id", int'(dut_id[0]), 0);
    chk("rst_ovf", int'(dut_ovf[0]), 0);
    chk("rst_busy", int'(dut_busy[0]), 0);
    rst_n = 1'b1;

    // Doubling: one pulse on requester 0 gives two tokens at t+2, t+3.
    @(negedge clk); a = 4'b0001; de = 4'b0001;
    @(negedge clk); a = '0; de = '0;
    chk("dbl_t1_b", int'(dut_b[0]), 0);
    @(negedge clk); chk("dbl_t2_b", int'(dut_b[0]), 1); chk("dbl_t2_id", int'(dut_id[0]), 0);
    @(negedge clk); chk("dbl_t3_b", int'(dut_b[0]), 1); chk("dbl_t3_id", int'(dut_id[0]), 0);
    @(negedge clk); chk("dbl_t4_b", int'(dut_b[0]), 0); chk("dbl_t4_busy", int'(dut_busy[0]), 0);

    // Fair sharing from reset pointer.
    do_reset();
    a = 4'b1111;
    @(negedge clk); a = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("fair0_b%0d", k), int'(dut_b[0]), 1);
      chk($sformatf("fair0_id%0d", k), int'(dut_id[0]), k);
    end
    @(negedge clk); chk("fair0_end", int'(dut_b[0]), 0);

    // Fair sharing after serving requester 1 alone.
    do_reset();
    a = 4'b0010;
    @(negedge clk); a = '0;
    repeat (3) @(negedge clk);
    a = 4'b1111;
    @(negedge clk); a = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("fair1_id%0d", k), int'(dut_id[0]), (k + 2) % 4);
    end

    // Backpressure: slot holds id 0 while requester 2 posts twice.
    do_reset();
    b_ready = 1'b0; a = 4'b0001;
    @(negedge clk); a = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_b%0d", k), int'(dut_b[0]), 1);
      chk($sformatf("bp_hold_id%0d", k), int'(dut_id[0]), 0);
      a = (k == 0 || k == 2) ? 4'b0100 : 4'b0000;
    end
    a = '0; b_ready = 1'b1;
    @(negedge clk); chk("bp_rel_id0", int'(dut_id[0]), 2); chk("bp_rel_b0", int'(dut_b[0]), 1);
    @(negedge clk); chk("bp_rel_id1", int'(dut_id[0]), 2); chk("bp_rel_b1", int'(dut_b[0]), 1);
    @(negedge clk); chk("bp_rel_end", int'(dut_b[0]), 0);

    // Overflow: requester 1 doubled and held high under backpressure.
    do_reset();
    b_ready = 1'b0; de = 4'b0010; a = 4'b0010;
    repeat (10) @(negedge clk);
    chk("ovf_rise", int'(dut_ovf[0]), 2);
    repeat (10) @(negedge clk);
    a = '0; de = '0; b_ready = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (!dut_b[0]) break;
      if (dut_id[0] != 2'd1) chk("ovf_drain_id", int'(dut_id[0]), 1);
      cnt++;
      @(negedge clk);
    end
    chk("ovf_drain_cnt", cnt, 16);
    chk("ovf_sticky", int'(dut_ovf[0]), 2);

    // Random conservation, judged on the CNT_W=8 instance.
    do_reset();
    for (int i = 0; i < 4; i++) begin acc[i] = 0; posted[i] = 0; end
    b_ready = 1'b1;
    de = 4'($urandom_range(0, 15));
    cons_en = 1'b1;
    for (int c = 0; c < 100; c++) begin
      for (int i = 0; i < 4; i++) begin
        a[i] = ($urandom_range(0, 9) == 0);
        if (a[i]) posted[i] += de[i] ? 2 : 1;
      end
      @(negedge clk);
    end
    a = '0;
    repeat (200) @(negedge clk);
    cons_en = 1'b0;
    for (int i = 0; i < 4; i++) chk($sformatf("cons_id%0d", i), acc[i], posted[i]);
    chk("cons_ovf", int'(dut_ovf[1]), 0);
    chk("cons_busy", int'(dut_busy[1]), 0);

    // Reset mid-operation discards everything, then a fresh token flows normally.
    a = 4'b1111;
    @(negedge clk); a = '0;
    @(negedge clk);
    chk("mid_pre_b", int'(dut_b[0]), 1);
    rst_n = 1'b0; a = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1; a = '0;
    chk("mid_b", int'(dut_b[0]), 0);
    chk("mid_busy", int'(dut_busy[0]), 0);
    chk("mid_ovf", int'(dut_ovf[0]), 0);
    a = 4'b1000;
    @(negedge clk); a = '0;
    @(negedge clk);
    chk("mid_tok_b", int'(dut_b[0]), 1);
    chk("mid_tok_id", int'(dut_id[0]), 3);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/token_scheduler.md
# token_scheduler

Round-robin scheduler that lets several token sources share one token output channel. Each requester posts single-cycle token pulses. Each pulse is worth one or two output tokens, selected per requester (doubling mode). Pending tokens are counted per requester and issued one per cycle through a single valid/ready output slot. Saturating per-requester counters flag lost tokens with a sticky overflow bit. The block sits between token producers and a single downstream token consumer.

## Interface
- N, 4 — number of requesters, ≥ 2.
- CNT_W, 4 — width of each per-requester pending counter; maximum count MAX = 2^CNT_W − 1.
- ID_W, $clog2(N) — width of b_id (derived, not overridden).

- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- a  input  N  token pulses; a[i]=1 in a cycle means requester i posts one input token.
- double_en  input  N  per-requester weight, sampled in the same cycle as a[i]: 1 → 2 output tokens, 0 → 1 output token.
- b_ready  input  1  downstream accepts the offered token this cycle.
- b  output  1  output slot holds a token (valid).
- b_id  output  ID_W  requester owning the offered token; meaningful only while b=1.
- overflow  output  N  sticky; overflow[i]=1 once requester i has lost a token.
- busy  output  1  b | any pending counter non-zero.

## Operation
- State:
  - pending[i] (CNT_W bits) per requester.
  - Output slot registers b and b_id.
  - Round-robin pointer ptr (ID_W bits) = id of the last token loaded into the slot.
  - overflow[i].
- Weight: w_i = a[i] ? (double_en[i] ? 2 : 1) : 0.
- Load condition: load = !b | b_ready, meaning the slot is empty or the token in it is being accepted this cycle.
- Winner selection:
  - Candidates are requesters with registered pending[i] ≠ 0.
  - Search is cyclic, starting at ptr+1 mod N and wrapping past N−1 to 0.
  - The first candidate found wins. A requester is reconsidered only after all others with pending tokens have been served.
- On load with a winner k:
  - b ← 1, b_id ← k, ptr ← k.
  - pending[k] is decremented by 1.
- On load with no candidate: b ← 0; b_id and ptr hold.
- No load (b=1, b_ready=0): b, b_id and ptr hold. The offered token and id must stay stable until accepted.
- Counter update per cycle: next = pending[i] + w_i − (load & winner==i). The sum is computed at CNT_W+2 bits.
  - A simultaneous input pulse and load on the same requester net to +1 (weight 2) or 0 (weight 1).
  - If next > MAX: pending[i] ← MAX and overflow[i] ← 1. Excess tokens are discarded.
  - overflow[i] clears only on reset.
- A token counted into pending is never dropped; it is eventually issued, since round-robin guarantees service.
- Reset (rst_n=0 at an edge), including mid-operation:
  - All pending ← 0, b ← 0, b_id ← 0, ptr ← N−1 (so the first search starts at requester 0), overflow ← 0.
  - Any token in flight is discarded.
  - a is ignored during reset cycles.

## Timing
- Reset values: b=0, b_id=0, overflow=0, busy=0.
- Outputs b, b_id and overflow come directly from registers. busy is combinational from registers.
- Latency: pulse on a[i] in cycle t → pending[i] non-zero in cycle t+1 → b=1 with b_id=i from cycle t+2, when the slot is free.
- Throughput: one token per cycle while b_ready=1 and tokens are pending. There are no idle bubbles between back-to-back tokens, from the same or different requesters.
- A token is transferred in a cycle with b=1 and b_ready=1. The next token, if any, appears in the following cycle.
- overflow[i] rises in the cycle after the edge at which saturation occurred.
- After sources go quiet with b_ready=1, busy falls within 1 + Σ pending cycles.

## Test plan
- Doubling path: N=4, CNT_W=4, b_ready=1, double_en[0]=1, single pulse a[0] at cycle t.
  - Required: b=1, b_id=0 in cycles t+2 and t+3; b=0 from t+4; busy=0 from t+4.
- Fair sharing: a=4'b1111 for one cycle, double_en=0, b_ready=1.
  - Required: b_id = 0,1,2,3 in consecutive cycles t+2..t+5, then b=0.
  - Repeat with ptr=1 preset by a prior single a[1] token; then the order must be 2,3,0,1.
- Backpressure: one token offered, b_ready=0 for 5 cycles while a[2] pulses twice.
  - Required: b and b_id remain constant across all 5 cycles, and pending[2] = 2.
  - On releasing b_ready: exactly one offer per cycle; total of 3 tokens received.
- Overflow: CNT_W=4, b_ready=0, double_en[1]=1, a[1] held high 20 cycles.
  - Required: overflow[1]=1 within 10 cycles; other overflow bits stay 0.
  - After a=0 and b_ready=1: exactly 16 tokens with b_id=1 drain (15 pending + 1 in slot); overflow[1] stays 1.
- Random conservation: CNT_W=8, b_ready=1, a[i] random at 10% each, double_en random per requester, 100 cycles, then 200 idle cycles.
  - Required: per id, accepted output tokens = Σ weights of posted input tokens; overflow=0; busy=0 at end.
- Reset mid-operation: with pending tokens and b=1, drive rst_n=0 for one cycle.
  - Required: next cycle b=0, busy=0, overflow=0.
  - A subsequent single a[3] token appears as b_id=3 two cycles later.
